// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - word request, byte memory and status bundle for dmem_port_arbiter
//
// Purpose: groups the CPU and DBG word ports, the byte-wide data memory port
// and the busy/owner status of the arbiter into one bundle.
//   slave  : arbiter side (takes requests, drives the memory)
//   master : requester/memory side (testbench or surrounding datapath)
// Signals:
//   cpu_req/we/addr/wdata -> , cpu_rdata/ack <-  CPU word port
//   dbg_req/we/addr/wdata -> , dbg_rdata/ack <-  DBG word port
//   mem_addr/we/wdata <- , mem_rdata ->          byte memory (combinational read)
//   busy, owner <-                               arbiter status
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 5
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ack;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic [31:0]       dbg_rdata;
  logic              dbg_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin CPU/DBG arbiter splitting 32-bit words into big-endian byte accesses
//
// Purpose: serialises word reads/writes from the CPU and the debug/loader port
// onto a single byte-wide data memory. Each word takes four byte cycles
// (XFER, byte k at base+k, MSB first) followed by one DONE cycle carrying the
// owner's ack. Ties in IDLE go to the requester that was not granted last.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dmem_port_arbiter_if.slave (CPU/DBG word ports, byte memory, busy/owner)
module dmem_port_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [1:0]        r_cnt;
  // owner doubles as last_grant: it is only rewritten on a grant.
  logic              r_owner;
  logic              r_we;
  logic [23:0]       r_wdata_lo;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic [23:0]       r_asm;
  logic [31:0]       r_cpu_rdata;
  logic [31:0]       r_dbg_rdata;

  logic              w_req_any;
  logic              w_grant_dbg;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [7:0]        w_next_byte;
  logic              w_mem_we;
  logic              w_busy;
  logic              w_cpu_ack;
  logic              w_dbg_ack;

  // Round robin: DBG wins only when alone or when the CPU held the last grant.
  assign w_req_any   = bus.cpu_req | bus.dbg_req;
  assign w_grant_dbg = bus.dbg_req & (~bus.cpu_req | ~r_owner);
  assign w_sel_we    = w_grant_dbg ? bus.dbg_we    : bus.cpu_we;
  assign w_sel_addr  = w_grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
  assign w_sel_wdata = w_grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;

  // Byte to present in the cycle after the current one (k+1).
  always_comb begin
    w_next_byte = r_wdata_lo[23:16];
    case (r_cnt)
      2'd0:    w_next_byte = r_wdata_lo[23:16];
      2'd1:    w_next_byte = r_wdata_lo[15:8];
      default: w_next_byte = r_wdata_lo[7:0];
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_next = S_XFER;
      S_XFER:  if (r_cnt == 2'd3) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; async reset clears them immediately.
  always_comb begin
    w_mem_we  = 1'b0;
    w_busy    = 1'b0;
    w_cpu_ack = 1'b0;
    w_dbg_ack = 1'b0;
    case (r_state)
      S_XFER: begin
        w_mem_we = r_we;
        w_busy   = 1'b1;
      end
      S_DONE: begin
        w_busy    = 1'b1;
        w_cpu_ack = ~r_owner;
        w_dbg_ack = r_owner;
      end
      default: ;
    endcase
  end

  // Datapath: request latch, byte sequencing, read assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 2'd0;
      r_owner     <= 1'b1;
      r_we        <= 1'b0;
      r_wdata_lo  <= 24'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;
      r_asm       <= 24'd0;
      r_cpu_rdata <= 32'd0;
      r_dbg_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_owner     <= w_grant_dbg;
            r_we        <= w_sel_we;
            r_wdata_lo  <= w_sel_wdata[23:0];
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata[31:24];
            r_cnt       <= 2'd0;
          end
        end
        S_XFER: begin
          r_cnt <= r_cnt + 2'd1;
          r_asm <= {r_asm[15:0], bus.mem_rdata};
          if (r_cnt != 2'd3) begin
            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
            r_mem_wdata <= w_next_byte;
          end else if (!r_we) begin
            // Last byte bypasses the assembly register so rdata is valid in DONE.
            if (r_owner) r_dbg_rdata <= {r_asm, bus.mem_rdata};
            else         r_cpu_rdata <= {r_asm, bus.mem_rdata};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dbg_rdata = r_dbg_rdata;
  assign bus.cpu_ack   = w_cpu_ack;
  assign bus.dbg_ack   = w_dbg_ack;
  assign bus.busy      = w_busy;
  assign bus.owner     = r_owner;

endmodule
